// File: rtl/iagc_gain_controller_if.sv
// Signal bundle between the IAGC controller and the phase detector / gain stage.
// Directions are named from the controller's point of view.
interface iagc_gain_controller_if #(
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int GAIN_SIZE        = 12
);
  logic                        i_enable;
  logic                        i_sample;
  logic                        i_in_phase;
  logic [IAGC_STATUS_SIZE-1:0] o_iagc_status;
  logic [GAIN_SIZE-1:0]        o_gain;
  logic                        o_gain_valid;
  logic                        o_locked;
  logic                        o_busy;

  modport master (
    input  i_enable, i_sample, i_in_phase,
    output o_iagc_status, o_gain, o_gain_valid, o_locked, o_busy
  );

  modport slave (
    output i_enable, i_sample, i_in_phase,
    input  o_iagc_status, o_gain, o_gain_valid, o_locked, o_busy
  );
endinterface

// File: rtl/iagc_gain_controller.sv
// IAGC loop sequencer: arms the phase detector, counts the sample window and
// walks the gain code by successive approximation until it dithers at step 1.
module iagc_gain_controller #(
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int PHASE_COUNT_SIZE = 16,
  parameter int GAIN_SIZE        = 12,
  parameter int RESULT_LATENCY   = 3,
  parameter int LOCK_REVERSALS   = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic [PHASE_COUNT_SIZE-1:0] i_phase_count,
  input  logic [PHASE_COUNT_SIZE-1:0] i_settle_count,
  input  logic [GAIN_SIZE-1:0]        i_gain_init,
  input  logic [GAIN_SIZE-1:0]        i_gain_min,
  input  logic [GAIN_SIZE-1:0]        i_gain_max,
  input  logic [GAIN_SIZE-1:0]        i_step_init,
  iagc_gain_controller_if.master      io_bus
);
  localparam int CW    = PHASE_COUNT_SIZE;
  localparam int REV_W = $clog2(LOCK_REVERSALS + 1);
  localparam logic [IAGC_STATUS_SIZE-1:0] STATUS_HOLD = {IAGC_STATUS_SIZE{1'b0}};
  localparam logic [IAGC_STATUS_SIZE-1:0] STATUS_RUN  = {{(IAGC_STATUS_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0]        ARM_LAST    = CW'(1);
  localparam logic [CW-1:0]        RESULT_LAST = CW'(RESULT_LATENCY - 1);
  localparam logic [GAIN_SIZE-1:0] GAIN_ONE    = {{(GAIN_SIZE-1){1'b0}}, 1'b1};
  localparam logic [REV_W-1:0]     REV_ZERO    = {REV_W{1'b0}};
  localparam logic [REV_W-1:0]     REV_ONE     = {{(REV_W-1){1'b0}}, 1'b1};
  localparam logic [REV_W-1:0]     REV_LOCK    = REV_W'(LOCK_REVERSALS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_MEASURE = 3'd2,
    ST_RESULT  = 3'd3,
    ST_UPDATE  = 3'd4,
    ST_SETTLE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  state_t                      r_state, w_state_next;
  dir_t                        r_dir, w_dir_next, w_dir_new;
  logic [CW-1:0]               r_cnt, w_cnt_next;
  logic [CW:0]                 w_cnt_inc;
  logic [GAIN_SIZE-1:0]        r_gain, w_gain_next, w_gain_new, w_gain_load;
  logic [GAIN_SIZE-1:0]        r_step, w_step_next, w_step_new, w_step_half;
  logic [GAIN_SIZE:0]          w_sum;
  logic [REV_W-1:0]            r_rev, w_rev_next, w_rev_new;
  logic                        r_verdict, w_verdict_next;
  logic                        r_gain_valid, w_gain_valid_next;
  logic                        r_locked, w_locked_next;
  logic                        r_busy;
  logic [IAGC_STATUS_SIZE-1:0] r_status, w_status_next;

  // Gain/step/reversal candidates for the UPDATE cycle, plus the clamped start gain.
  always_comb begin
    w_dir_new   = r_verdict ? DIR_UP : DIR_DOWN;
    w_step_half = r_step >> 1;
    w_step_new  = r_step;
    w_rev_new   = r_rev;
    if ((r_dir != DIR_NONE) && (r_dir != w_dir_new)) begin
      w_step_new = (w_step_half == {GAIN_SIZE{1'b0}}) ? GAIN_ONE : w_step_half;
      if (r_step == GAIN_ONE) begin
        w_rev_new = (r_rev == REV_LOCK) ? r_rev : (r_rev + REV_ONE);
      end else begin
        w_rev_new = REV_ZERO;
      end
    end else if (r_dir == w_dir_new) begin
      w_rev_new = REV_ZERO;
    end else begin
      w_rev_new = r_rev;
    end

    // One extra bit keeps both overflow and borrow visible before clamping.
    if (w_dir_new == DIR_UP) begin
      w_sum = {1'b0, r_gain} + {1'b0, w_step_new};
    end else begin
      w_sum = {1'b0, r_gain} - {1'b0, w_step_new};
    end

    if ((w_dir_new == DIR_DOWN) && w_sum[GAIN_SIZE]) begin
      w_gain_new = i_gain_min;
    end else if (w_sum > {1'b0, i_gain_max}) begin
      w_gain_new = i_gain_max;
    end else if (w_sum < {1'b0, i_gain_min}) begin
      w_gain_new = i_gain_min;
    end else begin
      w_gain_new = w_sum[GAIN_SIZE-1:0];
    end

    if (i_gain_init < i_gain_min) begin
      w_gain_load = i_gain_min;
    end else if (i_gain_init > i_gain_max) begin
      w_gain_load = i_gain_max;
    end else begin
      w_gain_load = i_gain_init;
    end
  end

  // Next-state and next-register logic; dropping i_enable overrides every state.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_gain_next       = r_gain;
    w_gain_valid_next = 1'b0;
    w_locked_next     = r_locked;
    w_step_next       = r_step;
    w_dir_next        = r_dir;
    w_rev_next        = r_rev;
    w_verdict_next    = r_verdict;
    w_cnt_inc         = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};

    if ((r_state != ST_IDLE) && !io_bus.i_enable) begin
      w_state_next  = ST_IDLE;
      w_cnt_next    = CNT_ZERO;
      w_locked_next = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.i_enable) begin
            w_state_next      = ST_ARM;
            w_cnt_next        = CNT_ZERO;
            w_gain_next       = w_gain_load;
            w_gain_valid_next = 1'b1;
            w_step_next       = i_step_init;
            w_dir_next        = DIR_NONE;
            w_rev_next        = REV_ZERO;
            w_locked_next     = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_ARM: begin
          if (r_cnt == ARM_LAST) begin
            w_state_next = ST_MEASURE;
            w_cnt_next   = CNT_ZERO;
          end else begin
            w_cnt_next = w_cnt_inc[CW-1:0];
          end
        end
        ST_MEASURE: begin
          if (io_bus.i_sample) begin
            if (w_cnt_inc == {1'b0, i_phase_count}) begin
              w_state_next = ST_RESULT;
              w_cnt_next   = CNT_ZERO;
            end else begin
              w_cnt_next = w_cnt_inc[CW-1:0];
            end
          end else begin
            w_cnt_next = r_cnt;
          end
        end
        ST_RESULT: begin
          if (r_cnt == RESULT_LAST) begin
            w_verdict_next = io_bus.i_in_phase;
            w_state_next   = ST_UPDATE;
            w_cnt_next     = CNT_ZERO;
          end else begin
            w_cnt_next = w_cnt_inc[CW-1:0];
          end
        end
        ST_UPDATE: begin
          w_gain_next       = w_gain_new;
          w_gain_valid_next = (w_gain_new != r_gain);
          w_step_next       = w_step_new;
          w_rev_next        = w_rev_new;
          w_dir_next        = w_dir_new;
          w_locked_next     = r_locked | (w_rev_new == REV_LOCK);
          w_state_next      = ST_SETTLE;
          w_cnt_next        = CNT_ZERO;
        end
        ST_SETTLE: begin
          if (i_settle_count == CNT_ZERO) begin
            w_state_next = ST_ARM;
            w_cnt_next   = CNT_ZERO;
          end else if (io_bus.i_sample) begin
            if (w_cnt_inc == {1'b0, i_settle_count}) begin
              w_state_next = ST_ARM;
              w_cnt_next   = CNT_ZERO;
            end else begin
              w_cnt_next = w_cnt_inc[CW-1:0];
            end
          end else begin
            w_cnt_next = r_cnt;
          end
        end
        default: begin
          w_state_next  = ST_IDLE;
          w_cnt_next    = CNT_ZERO;
          w_locked_next = 1'b0;
        end
      endcase
    end

    w_status_next = ((w_state_next == ST_ARM) || (w_state_next == ST_MEASURE) ||
                     (w_state_next == ST_RESULT)) ? STATUS_RUN : STATUS_HOLD;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= CNT_ZERO;
      r_gain       <= {GAIN_SIZE{1'b0}};
      r_gain_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_step       <= {GAIN_SIZE{1'b0}};
      r_dir        <= DIR_NONE;
      r_rev        <= REV_ZERO;
      r_verdict    <= 1'b0;
      r_status     <= STATUS_HOLD;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_gain       <= w_gain_next;
      r_gain_valid <= w_gain_valid_next;
      r_locked     <= w_locked_next;
      r_step       <= w_step_next;
      r_dir        <= w_dir_next;
      r_rev        <= w_rev_next;
      r_verdict    <= w_verdict_next;
      r_status     <= w_status_next;
      r_busy       <= (w_state_next != ST_IDLE);
    end
  end

  assign io_bus.o_iagc_status = r_status;
  assign io_bus.o_gain        = r_gain;
  assign io_bus.o_gain_valid  = r_gain_valid;
  assign io_bus.o_locked      = r_locked;
  assign io_bus.o_busy        = r_busy;
endmodule

// File: tb/tb_iagc_gain_controller.sv
// Randomised bench: drives whole measurement iterations and compares every
// observable against a transaction-level model of the successive-approximation loop.
module tb_iagc_gain_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] p_cnt, s_cnt;
  logic [11:0] g_init, g_min, g_max, st_init;
  int n_checks = 0;
  int n_fail   = 0;
  int m_gain, m_step, m_dir, m_rev, m_lo, m_hi;
  bit m_locked, m_changed;

  iagc_gain_controller_if #(.IAGC_STATUS_SIZE(4), .GAIN_SIZE(12)) bus ();

  iagc_gain_controller #(
    .IAGC_STATUS_SIZE(4), .PHASE_COUNT_SIZE(16), .GAIN_SIZE(12),
    .RESULT_LATENCY(3), .LOCK_REVERSALS(4)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_phase_count(p_cnt), .i_settle_count(s_cnt),
    .i_gain_init(g_init), .i_gain_min(g_min), .i_gain_max(g_max), .i_step_init(st_init),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // One loop decision: direction, step halving on reversal, saturating gain.
  function automatic void model_update(input bit verdict);
    int dir = verdict ? 1 : -1;
    int ng;
    if (m_dir != 0 && dir != m_dir) begin
      m_rev  = (m_step == 1) ? m_rev + 1 : 0;
      m_step = (m_step / 2 < 1) ? 1 : m_step / 2;
    end else if (m_dir == dir) begin
      m_rev = 0;
    end
    ng = m_gain + dir * m_step;
    if (ng > m_hi) ng = m_hi;
    if (ng < m_lo) ng = m_lo;
    m_changed = (ng != m_gain);
    m_gain    = ng;
    m_dir     = dir;
    if (m_rev >= 4) m_locked = 1'b1;
  endfunction

  // From IDLE: program the loop, enable, and check the start-up load.
  task automatic start_loop(input int init, input int lo, input int hi, input int step,
                            input int p, input int s);
    g_init = 12'(init); g_min = 12'(lo); g_max = 12'(hi); st_init = 12'(step);
    p_cnt = 16'(p); s_cnt = 16'(s);
    bus.i_enable = 1'b1; bus.i_sample = 1'b0;
    tick();
    m_lo = lo; m_hi = hi; m_step = step; m_dir = 0; m_rev = 0; m_locked = 1'b0;
    m_gain = (init < lo) ? lo : ((init > hi) ? hi : init);
    n_checks++;
    if (bus.o_gain !== 12'(m_gain) || bus.o_gain_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL start_load: gain=%0h valid=%b expected gain=%0h valid=1", bus.o_gain, bus.o_gain_valid, m_gain);
    end
    n_checks++;
    if (bus.o_iagc_status !== 4'h1 || bus.o_busy !== 1'b1 || bus.o_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL start_arm: status=%0h busy=%b locked=%b expected 1/1/0", bus.o_iagc_status, bus.o_busy, bus.o_locked);
    end
  endtask

  // From ARM entry: disable and check the drop to IDLE with the gain held.
  task automatic stop_loop();
    bus.i_enable = 1'b0;
    tick();
    n_checks++;
    if (bus.o_iagc_status !== 4'h0 || bus.o_busy !== 1'b0 || bus.o_locked !== 1'b0 ||
        bus.o_gain !== 12'(m_gain) || bus.o_gain_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_idle: status=%0h busy=%b locked=%b gain=%0h valid=%b expected 0/0/0/%0h/0",
               bus.o_iagc_status, bus.o_busy, bus.o_locked, bus.o_gain, bus.o_gain_valid, m_gain);
    end
    m_locked = 1'b0;
  endtask

  // One full iteration ARM..SETTLE, starting and ending at the ARM entry.
  task automatic run_cycle(input bit verdict, input bit arm_strobe, input bit upd_strobe);
    int p = int'(p_cnt);
    int s = int'(s_cnt);
    bus.i_sample = arm_strobe;
    bus.i_in_phase = ~verdict;
    tick();
    n_checks++;
    if (bus.o_iagc_status !== 4'h1 || bus.o_gain_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_hold: status=%0h valid=%b expected 1/0", bus.o_iagc_status, bus.o_gain_valid);
    end
    tick();
    bus.i_sample = 1'b0;
    for (int k = 0; k < p; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      n_checks++;
      if (bus.o_iagc_status !== 4'h1 || bus.o_gain_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL measure_status: strobe %0d status=%0h valid=%b expected 1/0", k, bus.o_iagc_status, bus.o_gain_valid);
      end
      bus.i_sample = 1'b1;
      tick();
      bus.i_sample = 1'b0;
    end
    for (int r = 0; r < 3; r++) begin
      n_checks++;
      if (bus.o_iagc_status !== 4'h1) begin
        n_fail++;
        $display("FAIL result_status: cycle %0d status=%0h expected 1", r, bus.o_iagc_status);
      end
      bus.i_in_phase = (r == 2) ? verdict : ~verdict;
      tick();
    end
    bus.i_in_phase = ~verdict;
    n_checks++;
    if (bus.o_iagc_status !== 4'h0 || bus.o_gain !== 12'(m_gain) || bus.o_gain_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL update_state: status=%0h gain=%0h valid=%b expected 0/%0h/0", bus.o_iagc_status, bus.o_gain, bus.o_gain_valid, m_gain);
    end
    model_update(verdict);
    bus.i_sample = upd_strobe;
    tick();
    bus.i_sample = 1'b0;
    n_checks++;
    if (bus.o_gain !== 12'(m_gain) || bus.o_gain_valid !== m_changed || bus.o_locked !== m_locked ||
        bus.o_iagc_status !== 4'h0 || bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL gain_update: gain=%0h valid=%b locked=%b status=%0h busy=%b expected %0h/%b/%b/0/1",
               bus.o_gain, bus.o_gain_valid, bus.o_locked, bus.o_iagc_status, bus.o_busy, m_gain, m_changed, m_locked);
    end
    if (s == 0) begin
      tick();
    end else begin
      for (int k = 0; k < s; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        n_checks++;
        if (bus.o_iagc_status !== 4'h0) begin
          n_fail++;
          $display("FAIL settle_status: strobe %0d status=%0h expected 0", k, bus.o_iagc_status);
        end
        bus.i_sample = 1'b1;
        tick();
        bus.i_sample = 1'b0;
      end
    end
    n_checks++;
    if (bus.o_iagc_status !== 4'h1 || bus.o_gain_valid !== 1'b0 || bus.o_gain !== 12'(m_gain)) begin
      n_fail++;
      $display("FAIL rearm: status=%0h valid=%b gain=%0h expected 1/0/%0h", bus.o_iagc_status, bus.o_gain_valid, bus.o_gain, m_gain);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_enable = 1'b0; bus.i_sample = 1'b0; bus.i_in_phase = 1'b0;
    p_cnt = 16'd0; s_cnt = 16'd0; g_init = 12'h0; g_min = 12'h0; g_max = 12'h0; st_init = 12'h0;
    repeat (3) tick();
    n_checks++;
    if (bus.o_iagc_status !== 4'h0 || bus.o_gain !== 12'h0 || bus.o_gain_valid !== 1'b0 ||
        bus.o_locked !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: status=%0h gain=%0h valid=%b locked=%b busy=%b expected all 0",
               bus.o_iagc_status, bus.o_gain, bus.o_gain_valid, bus.o_locked, bus.o_busy);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_iagc_status !== 4'h0) begin
      n_fail++;
      $display("FAIL idle_without_enable: busy=%b status=%0h expected 0/0", bus.o_busy, bus.o_iagc_status);
    end
  endtask

  task automatic test_start_ascend();
    start_loop(32'h400, 32'h0, 32'hFFF, 32'h100, 8, 4);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.o_gain !== 12'h700) begin
      n_fail++;
      $display("FAIL ascend_gain: gain=%0h expected 700", bus.o_gain);
    end
  endtask

  task automatic test_binary_search_lock();
    stop_loop();
    start_loop(32'h400, 32'h0, 32'hFFF, 32'h100, 8, $urandom_range(0, 4));
    for (int i = 0; i < 15; i++) begin
      run_cycle((i % 2) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    n_checks++;
    if (bus.o_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_reached: locked=%b expected 1", bus.o_locked);
    end
  endtask

  task automatic test_disable_mid_measure();
    int lo = $urandom_range(0, 32'h7FF);
    int hi = $urandom_range(lo, 32'hFFF);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.i_sample = 1'b1;
      tick();
      bus.i_sample = 1'b0;
    end
    bus.i_enable = 1'b0;
    tick();
    n_checks++;
    if (bus.o_iagc_status !== 4'h0 || bus.o_locked !== 1'b0 || bus.o_busy !== 1'b0 ||
        bus.o_gain !== 12'(m_gain)) begin
      n_fail++;
      $display("FAIL disable_idle: status=%0h locked=%b busy=%b gain=%0h expected 0/0/0/%0h",
               bus.o_iagc_status, bus.o_locked, bus.o_busy, bus.o_gain, m_gain);
    end
    start_loop($urandom_range(0, 32'hFFF), lo, hi, $urandom_range(1, 32'h200),
               $urandom_range(1, 3), $urandom_range(0, 2));
  endtask

  task automatic test_random_walk();
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_saturation();
    stop_loop();
    start_loop(32'hFF0, 32'h0, 32'hFFF, 32'h40, 2, 1);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.o_gain !== 12'hFFF) begin
      n_fail++;
      $display("FAIL saturate_hold: gain=%0h expected fff", bus.o_gain);
    end
  endtask

  task automatic test_arm_p1_reset();
    stop_loop();
    start_loop(32'h200, 32'h0, 32'hFFF, 32'h10, 1, $urandom_range(0, 2));
    run_cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    bus.i_sample = 1'b1;
    repeat (3) tick();
    bus.i_sample = 1'b0;
    n_checks++;
    if (bus.o_iagc_status !== 4'h1 || bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL p1_result: status=%0h busy=%b expected 1/1", bus.o_iagc_status, bus.o_busy);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (bus.o_iagc_status !== 4'h0 || bus.o_gain !== 12'h0 || bus.o_gain_valid !== 1'b0 ||
        bus.o_locked !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_result: status=%0h gain=%0h valid=%b locked=%b busy=%b expected all 0",
               bus.o_iagc_status, bus.o_gain, bus.o_gain_valid, bus.o_locked, bus.o_busy);
    end
    bus.i_enable = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_start_ascend();
    test_binary_search_lock();
    test_disable_mid_measure();
    test_random_walk();
    test_saturation();
    test_arm_p1_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
